// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the request channel (abstract operation in) and the instruction
//   channel (encoded RV32 words out) of instr_encoder.
//
//   Signals
//     req_valid / req_ready      request handshake (accepted when both high)
//     req_op, req_funct3         operation selector and funct3
//     req_rd, req_rs1, req_rs2   register fields (rs1 doubles as CSR uimm)
//     req_imm                    immediate / CSR address / SYS selector
//     instr_valid / instr_ready  instruction handshake
//     instr, instr_last          encoded word and final-word flag
//     err                        one-cycle pulse for an illegal request
//     instr_count                words handed out since reset (wrapping)
//
//   Modports
//     master : requester / instruction consumer side
//     slave  : encoder side
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [2:0]       req_funct3;
  logic [4:0]       req_rd;
  logic [4:0]       req_rs1;
  logic [4:0]       req_rs2;
  logic [31:0]      req_imm;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             instr_last;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output req_valid, req_op, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    output instr_ready,
    input  req_ready, instr_valid, instr, instr_last, err, instr_count
  );

  modport slave (
    input  req_valid, req_op, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    input  instr_ready,
    output req_ready, instr_valid, instr, instr_last, err, instr_count
  );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Turns abstract operation requests from the debug path into RV32 words
//   that are injected at the core decoder input. LI may expand into a
//   LUI+ADDI pair; the FSM hands words out one per valid/ready handshake.
//
//   Ports
//     clock_i  : rising-edge clock
//     reset_i  : synchronous, active-high reset
//     bus      : instr_encoder_if.slave (request in, instruction out)
//
//   Parameters
//     CSR_EN   : 1 allows OP_CSR, 0 makes it illegal
//     SYS_EN   : 1 allows OP_SYS, 0 makes it illegal
//     CNT_W    : width of instr_count
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter bit CSR_EN = 1'b1,
  parameter bit SYS_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic            clock_i,
  input  logic            reset_i,
  instr_encoder_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_LI    = 3'd0,
    OP_ALUI  = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_CSR   = 3'd4,
    OP_SYS   = 3'd5,
    OP_NOP   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // -------------------------------------------------------------------------
  // Encoder: pure function of the request fields
  // -------------------------------------------------------------------------
  op_e         op;
  logic [31:0] imm;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        li_fits_12;
  logic [19:0] li_hi;

  logic        enc_legal;
  logic        enc_two;
  logic [31:0] enc_w0;
  logic [31:0] enc_w1;

  assign op  = op_e'(bus.req_op);
  assign imm = bus.req_imm;
  assign f3  = bus.req_funct3;
  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;

  // Sign-extended 12-bit immediate covers the value when bits 31..11 agree.
  assign li_fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  // ADDI sign-extends its immediate, so the upper part is pre-compensated
  // by imm[11]; the 20-bit sum wraps on purpose.
  assign li_hi = imm[31:12] + {19'd0, imm[11]};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    enc_legal = 1'b1;
    enc_two   = 1'b0;
    enc_w0    = 32'h0000_0000;
    enc_w1    = 32'h0000_0000;
    unique case (op)
      OP_LI: begin
        if (li_fits_12) begin
          enc_w0 = {imm[11:0], 5'd0, 3'b000, rd, OPC_OP_IMM};
        end else begin
          enc_w0  = {li_hi, rd, OPC_LUI};
          enc_w1  = {imm[11:0], rd, 3'b000, rd, OPC_OP_IMM};
          enc_two = (imm[11:0] != 12'h000);
        end
      end
      OP_ALUI: begin
        enc_w0 = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
        // Shift-immediates only accept the SLLI/SRLI/SRAI upper patterns.
        if (f3 == 3'b001) begin
          enc_legal = (imm[11:5] == 7'b0000000);
        end else if (f3 == 3'b101) begin
          enc_legal = (imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b0100000);
        end
      end
      OP_LOAD: begin
        enc_w0    = {imm[11:0], rs1, f3, rd, OPC_LOAD};
        enc_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                    (f3 == 3'd4) || (f3 == 3'd5);
      end
      OP_STORE: begin
        enc_w0    = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
        enc_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      end
      OP_CSR: begin
        enc_w0    = {imm[11:0], rs1, f3, rd, OPC_SYSTEM};
        // funct3 0 is the SYSTEM privileged space and 4 is unassigned.
        enc_legal = CSR_EN && (f3 != 3'd0) && (f3 != 3'd4);
      end
      OP_SYS: begin
        enc_legal = SYS_EN;
        unique case (imm[1:0])
          2'd0:    enc_w0 = 32'h0000_0073;  // ECALL
          2'd1:    enc_w0 = 32'h0010_0073;  // EBREAK
          2'd2:    enc_w0 = 32'h3020_0073;  // MRET
          default: enc_w0 = 32'h1050_0073;  // WFI
        endcase
      end
      OP_NOP: begin
        enc_w0 = 32'h0000_0013;
      end
      default: begin
        enc_legal = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handout FSM
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             last_q, last_d;
  logic [31:0]      word1_q, word1_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fire;

  assign fire = (state_q != IDLE) && bus.instr_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    word1_d = word1_q;
    err_d   = 1'b0;
    count_d = fire ? count_q + CNT_W'(1) : count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (enc_legal) begin
            instr_d = enc_w0;
            last_d  = !enc_two;
            word1_d = enc_w1;
            state_d = EMIT1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT1: begin
        if (bus.instr_ready) begin
          // last_q low here means a second word is still pending.
          if (!last_q) begin
            instr_d = word1_q;
            last_d  = 1'b1;
            state_d = EMIT2;
          end else begin
            instr_d = 32'h0000_0000;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      EMIT2: begin
        if (bus.instr_ready) begin
          instr_d = 32'h0000_0000;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      instr_q <= 32'h0000_0000;
      last_q  <= 1'b0;
      word1_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      word1_q <= word1_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.instr_valid = (state_q != IDLE);
  assign bus.instr       = instr_q;
  assign bus.instr_last  = last_q;
  assign bus.err         = err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int CNT_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instr_encoder_if #(.CNT_W(CNT_W)) bus ();

  instr_encoder #(
    .CSR_EN (1'b1),
    .SYS_EN (1'b1),
    .CNT_W  (CNT_W)
  ) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] word, input logic last);
    exp_t e;
    e.word = word;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_ready_before_send", {31'd0, bus.req_ready}, 32'd1);
    bus.req_op     = op;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_imm    = imm;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid  = 1'b0;
  endtask

  // Consume every queued word, stalling each one for 'stall' cycles first.
  task automatic drain(input int stall);
    exp_t e;
    int   n;
    while (sb.size() > 0) begin
      n = 0;
      while (!bus.instr_valid && n < 50) begin
        step();
        n++;
      end
      check("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
      e = sb.pop_front();
      for (int i = 0; i < stall; i++) begin
        step();
        check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("hold_instr", bus.instr, e.word);
        check("hold_last", {31'd0, bus.instr_last}, {31'd0, e.last});
      end
      bus.instr_ready = 1'b1;
      check("instr", bus.instr, e.word);
      check("instr_last", {31'd0, bus.instr_last}, {31'd0, e.last});
      step();
      bus.instr_ready = 1'b0;
      exp_count++;
      check("instr_count", {16'd0, bus.instr_count}, exp_count);
    end
    check("valid_drops", {31'd0, bus.instr_valid}, 32'd0);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd1);
    check({tag, "_no_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    step();
    check({tag, "_err_pulse"}, {31'd0, bus.err}, 32'd0);
    check({tag, "_count"}, {16'd0, bus.instr_count}, exp_count);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_op      = 3'd0;
    bus.req_funct3  = 3'd0;
    bus.req_rd      = 5'd0;
    bus.req_rs1     = 5'd0;
    bus.req_rs2     = 5'd0;
    bus.req_imm     = 32'd0;
    bus.instr_ready = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_count", {16'd0, bus.instr_count}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_last", {31'd0, bus.instr_last}, 32'd0);
    reset = 1'b0;
    step();

    // LI x5,0x12345678 -> LUI + ADDI, with 1-cycle latency
    send(3'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    push(32'h1234_52B7, 1'b0);
    push(32'h6782_8293, 1'b1);
    check("li_latency", {31'd0, bus.instr_valid}, 32'd1);
    check("li_busy", {31'd0, bus.req_ready}, 32'd0);
    drain(0);

    // LI x1,-1 -> single ADDI
    send(3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    push(32'hFFF0_0093, 1'b1);
    drain(0);

    // LI x2,0x1800 -> hi compensated for negative low part
    send(3'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1800);
    push(32'h0000_2137, 1'b0);
    push(32'h8001_0113, 1'b1);
    drain(0);

    // LI x3,0x5000 -> LUI alone, zero low part
    send(3'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'h0000_5000);
    push(32'h0000_51B7, 1'b1);
    drain(0);

    // CSRRS x7,mstatus,x0 and MRET
    send(3'd4, 3'd2, 5'd7, 5'd0, 5'd0, 32'h0000_0300);
    push(32'h3000_23F3, 1'b1);
    drain(0);
    send(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0002);
    push(32'h3020_0073, 1'b1);
    drain(0);

    // SRAI x4,x6,5 ; SW x8,2044(x2) ; NOP
    send(3'd1, 3'd5, 5'd4, 5'd6, 5'd0, 32'h0000_0405);
    push(32'h4053_5213, 1'b1);
    drain(0);
    send(3'd3, 3'd2, 5'd0, 5'd2, 5'd8, 32'h0000_07FC);
    push(32'h7E81_2E23, 1'b1);
    drain(0);
    send(3'd6, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0000);
    push(32'h0000_0013, 1'b1);
    drain(0);

    // Illegal requests
    send(3'd2, 3'd3, 5'd1, 5'd2, 5'd0, 32'h0000_0010);
    expect_err("load_f3_3");
    send(3'd1, 3'd1, 5'd1, 5'd2, 5'd0, 32'h0000_0401);
    expect_err("slli_bad_imm");
    send(3'd7, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0000);
    expect_err("op_rsvd");

    // Back-pressure: words held while instr_ready is low
    send(3'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    push(32'h1234_52B7, 1'b0);
    push(32'h6782_8293, 1'b1);
    drain(3);

    // Reset during EMIT2 discards the pending word and the count
    send(3'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    bus.instr_ready = 1'b1;
    check("pre_rst_word0", bus.instr, 32'h1234_52B7);
    step();
    bus.instr_ready = 1'b0;
    check("pre_rst_word1", bus.instr, 32'h6782_8293);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    exp_count = 0;
    check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("mid_rst_count", {16'd0, bus.instr_count}, 32'd0);
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Normal operation after reset
    send(3'd6, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0000);
    push(32'h0000_0013, 1'b1);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
